uart_rx_engine: RTL and testbench

//  Serial UART receiver; the receive end of the link timed by baud_generator.

---
 rtl/uart_rx_engine.sv | 171 +++++++++++++++++
 tb/tb_uart_rx_engine.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_engine.sv
// 16x-oversampled UART receiver: synchronized rx, mid-bit sampling, LSB first, 8N1 by default.
// Define UART_RX_PARITY_EN to add a parity bit after the data (PARITY_ODD selects odd parity).
module uart_rx_engine #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inrx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] MID_TICK  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   rx_s_q, rx_s_d;
  logic                   rx_s_dly_q, rx_s_dly_d;
  logic [CW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   bit_tick;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   perr_q, perr_d;
`endif

  always_comb begin
    sync1_d    = rx;
    rx_s_d     = sync1_q;
    rx_s_dly_d = rx_s_q;
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit_q;
    perr_d     = 1'b0;
`endif
    // bit_tick marks the tick that lands in the middle of the current bit
    bit_tick = inrx && (tick_cnt_q == LAST_TICK);
    if (inrx) begin
      tick_cnt_d = (tick_cnt_q == LAST_TICK) ? '0 : tick_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_s_dly_q && !rx_s_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
        end
      end
      S_START: begin
        if (inrx && (tick_cnt_q == MID_TICK)) begin
          tick_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = rx_s_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (bit_tick) begin
          par_bit_d = rx_s_q;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_tick) begin
          state_d = S_IDLE;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = ((^shift_q) ^ PAR_ODD) != par_bit_q;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_s_dly_q <= 1'b1;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      rx_s_q     <= rx_s_d;
      rx_s_dly_q <= rx_s_dly_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q  <= par_bit_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = PAR_ODD & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
// Bench for uart_rx_engine: directed scenarios plus random frames, checked every cycle
// against a frame-level model that predicts the pulse cycle, flags, data and busy window.
module tb_uart_rx_engine;

  localparam int N    = 4;
  localparam int OS   = 16;
  localparam int BITP = OS * N;
  localparam bit PODD = 1'b0;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
  localparam int LAT1 = 671;
`else
  localparam int NPAR = 0;
  localparam int LAT1 = 607;
`endif

  typedef enum int {K_NONE, K_OK, K_FERR} kind_t;
  typedef struct {
    int         j0;
    int         k_end;
    kind_t      kind;
    logic [7:0] data;
    bit         perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inrx = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, rx_busy;

  uart_rx_engine #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .inrx       (inrx),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         chk_en = 1'b0;
  logic [7:0] last_data = 8'h00;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         valid_j = 0;
  exp_t       exp_q[$];

  int         cj;
  bit         busy_e, rv_e, fe_e, pe_e;
  exp_t       ce;
  int         t1_j0;
  int         r_mode;
  logic [7:0] r_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cyc %0d", name, act, expv, cyc);
    end
  endtask

  // Every call covers one clock: inputs set 1 ns after an edge, sampled at the next edge.
  task automatic step(input logic r);
    rx   = r;
    inrx = (cyc % N == 0);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic hold(input logic r, input int n);
    for (int i = 0; i < n; i++) step(r);
  endtask

  task automatic idle(input int n);
    hold(1'b1, n);
  endtask

  // Start edge driven at call j0 is accepted two clocks later; ticks fall on calls that are multiples of N.
  function automatic int k_for(input int j0, input int nticks);
    int first;
    first = ((j0 + 3 + N - 1) / N) * N;
    return first + (nticks - 1) * N;
  endfunction

  task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit pflip);
    exp_t e;
    e.j0    = cyc;
    e.k_end = k_for(cyc, OS / 2 + OS * (8 + NPAR + 1));
    e.kind  = stop_v ? K_OK : K_FERR;
    e.data  = d;
    e.perr  = pflip && stop_v && (NPAR == 1);
    exp_q.push_back(e);
    hold(1'b0, BITP);
    for (int i = 0; i < 8; i++) hold(d[i], BITP);
    if (NPAR == 1) hold((^d) ^ PODD ^ pflip, BITP);
    hold(stop_v, BITP);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    exp_t e;
    e.j0    = cyc;
    e.k_end = k_for(cyc, OS / 2 + OS * (8 + NPAR + 1));
    e.kind  = K_OK;
    e.data  = d;
    e.perr  = 1'b0;
    exp_q.push_back(e);
    hold(1'b0, BITP);
    for (int i = 0; i < nbits; i++) hold(d[i], BITP);
  endtask

  task automatic false_start();
    exp_t e;
    e.j0    = cyc;
    e.k_end = k_for(cyc, OS / 2);
    e.kind  = K_NONE;
    e.data  = 8'h00;
    e.perr  = 1'b0;
    exp_q.push_back(e);
    hold(1'b0, 3 * N);
    hold(1'b1, 8 * N);
  endtask

  task automatic do_reset(input string tag);
    chk_en = 1'b0;
    reset  = 1'b1;
    idle(3);
    exp_q.delete();
    chk({tag, "_rx_data"}, rx_data, 8'h00);
    chk({tag, "_rx_valid"}, rx_valid, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_parity_err"}, parity_err, 1'b0);
    chk({tag, "_rx_busy"}, rx_busy, 1'b0);
    reset     = 1'b0;
    last_data = 8'h00;
    chk_en    = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cj     = cyc - 1;
      busy_e = 1'b0;
      rv_e   = 1'b0;
      fe_e   = 1'b0;
      pe_e   = 1'b0;
      if (exp_q.size() > 0) begin
        ce = exp_q[0];
        if (cj >= ce.j0 + 2 && cj < ce.k_end) busy_e = 1'b1;
        if (cj == ce.k_end) begin
          if (ce.kind == K_OK) begin
            rv_e      = 1'b1;
            pe_e      = ce.perr;
            last_data = ce.data;
          end else if (ce.kind == K_FERR) begin
            fe_e = 1'b1;
          end
          exp_q.delete(0);
        end
      end
      if (rx_valid === 1'b1) begin
        n_valid++;
        valid_j = cj;
      end
      if (frame_err === 1'b1) n_ferr++;
      if (parity_err === 1'b1) n_perr++;
      chk("rx_valid", rx_valid, rv_e);
      chk("frame_err", frame_err, fe_e);
      chk("parity_err", parity_err, pe_e);
      chk("rx_busy", rx_busy, busy_e);
      chk("rx_data", rx_data, last_data);
    end
  end

  initial begin
    do_reset("reset");

    while (cyc % N != 1) idle(1);
    t1_j0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    chk("t1_data", rx_data, 8'hA5);
    chk("t1_count", n_valid, 1);
    chk("t1_latency", valid_j - t1_j0, LAT1);
    chk("t1_busy", rx_busy, 1'b0);

    false_start();
    idle(10);
    chk("t2_valid_count", n_valid, 1);
    chk("t2_ferr_count", n_ferr, 0);
    chk("t2_busy", rx_busy, 1'b0);

    send_frame(8'h3C, 1'b0, 1'b0);
    idle(BITP);
    chk("t3_ferr_count", n_ferr, 1);
    chk("t3_valid_count", n_valid, 1);
    chk("t3_data_kept", rx_data, 8'hA5);

    send_partial(8'h55, 3);
    do_reset("t4_midreset");
    idle(10);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    chk("t4_data", rx_data, 8'h81);
    chk("t4_valid_count", n_valid, 2);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(20);
    chk("t5_valid_count", n_valid, 4);
    chk("t5_data", rx_data, 8'hFF);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h81, 1'b1, 1'b1);
    idle(20);
    chk("t6_perr_count", n_perr, 1);
    chk("t6_data", rx_data, 8'h81);
    chk("t6_valid_count", n_valid, 5);
`endif

    for (int it = 0; it < 25; it++) begin
      r_mode = $urandom_range(0, 9);
      r_d    = 8'($urandom_range(0, 255));
      if (r_mode == 0) begin
        false_start();
        idle($urandom_range(0, 20));
      end else if (r_mode == 1) begin
        send_frame(r_d, 1'b0, 1'b0);
        idle(BITP + $urandom_range(0, 30));
      end else begin
        send_frame(r_d, 1'b1, (NPAR == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 50));
      end
    end
    idle(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
